// File: rtl/conv_transpose_stream_if.sv
// conv_transpose_stream_if: input pixel stream and output word stream, both valid/ready.
// The engine takes the slave view; the producer/consumer side takes the master view.
interface conv_transpose_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/conv_transpose_stream.sv
// conv_transpose_stream: streaming transposed convolution; each input pixel is scatter-accumulated
// through the filter into an out_size^2 buffer, then drained. Macro CONV_TRANSPOSE_SATURATE_EN selects saturation.
module conv_transpose_stream #(
  parameter int input_size  = 2,
  parameter int filter_size = 5,
  parameter int stride      = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [filter_size*filter_size-1:0][31:0] filter,
  conv_transpose_stream_if.slave                  io,
  output logic                                    busy,
  output logic                                    done
);
  localparam int out_size = (input_size - 1) * stride + filter_size;
  localparam int n_taps   = filter_size * filter_size;
  localparam int n_out    = out_size * out_size;
  localparam int rc_w     = (input_size > 1) ? $clog2(input_size) : 1;
  localparam int f_w      = $clog2(filter_size + 1);
  localparam int tap_w    = (n_taps > 1) ? $clog2(n_taps) : 1;
  localparam int out_w    = (n_out > 1) ? $clog2(n_out) : 1;

  localparam logic [rc_w-1:0]  last_rc  = rc_w'(input_size - 1);
  localparam logic [f_w-1:0]   last_f   = f_w'(filter_size - 1);
  localparam logic [tap_w-1:0] last_tap = tap_w'(n_taps - 1);
  localparam logic [out_w-1:0] last_out = out_w'(n_out - 1);

  typedef enum logic [1:0] {IDLE, ACCEPT, SCATTER, DRAIN} state_t;

  state_t state, state_n;

  logic [rc_w-1:0]    in_row, in_col, cur_row, cur_col;
  logic               last_pix;
  logic [f_w-1:0]     fr, fc;
  logic [tap_w-1:0]   k;
  logic [out_w-1:0]   j;
  logic signed [31:0] pixel;

  logic signed [31:0] weight [n_taps];
  logic        [31:0] acc    [n_out];

  logic [out_w-1:0]   scat_idx;
  logic        [31:0] acc_cur, acc_next, term;
  logic signed [63:0] prod, shifted;

  // Datapath: one filter tap per cycle into the output position it lands on.
  assign prod    = pixel * weight[k];
  assign shifted = prod >>> 15;
  assign acc_cur = acc[scat_idx];

  always_comb begin
    scat_idx = out_w'((int'(cur_row) * stride + int'(fr)) * out_size
                      + int'(cur_col) * stride + int'(fc));
  end

`ifdef CONV_TRANSPOSE_SATURATE_EN
  logic [32:0] sum_ext;

  always_comb begin
    if (shifted > 64'sh0000_0000_7FFF_FFFF)
      term = 32'h7FFF_FFFF;
    else if (shifted < -64'sh0000_0000_8000_0000)
      term = 32'h8000_0000;
    else
      term = shifted[31:0];
    sum_ext = {acc_cur[31], acc_cur} + {term[31], term};
    // Sign bits disagree only on overflow; clamp towards the sign of the true sum.
    if (sum_ext[32] != sum_ext[31])
      acc_next = sum_ext[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      acc_next = sum_ext[31:0];
  end
`else
  always_comb begin
    term     = 32'(shifted);
    acc_next = acc_cur + term;
  end
`endif

  // NOTE: accumulators and weights are plain storage with no reset; start loads/clears them,
  // which keeps rst off a wide fan-out and lets this map onto register files.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int i = 0; i < n_out; i++) acc[i] <= '0;
      for (int i = 0; i < n_taps; i++) weight[i] <= filter[i];
    end else if (state == SCATTER) begin
      acc[scat_idx] <= acc_next;
    end
  end

  // NOTE: every assignment in a clocked block is non-blocking so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_row   <= '0;
      in_col   <= '0;
      cur_row  <= '0;
      cur_col  <= '0;
      last_pix <= 1'b0;
      fr       <= '0;
      fc       <= '0;
      k        <= '0;
      j        <= '0;
      pixel    <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            in_row <= '0;
            in_col <= '0;
            j      <= '0;
          end
        end
        ACCEPT: begin
          if (io.in_valid) begin
            pixel    <= io.in_data;
            cur_row  <= in_row;
            cur_col  <= in_col;
            last_pix <= (in_row == last_rc) && (in_col == last_rc);
            fr       <= '0;
            fc       <= '0;
            k        <= '0;
            if (in_col == last_rc) begin
              in_col <= '0;
              in_row <= in_row + 1'b1;
            end else begin
              in_col <= in_col + 1'b1;
            end
          end
        end
        SCATTER: begin
          k <= k + 1'b1;
          if (fc == last_f) begin
            fc <= '0;
            fr <= fr + 1'b1;
          end else begin
            fc <= fc + 1'b1;
          end
        end
        DRAIN: begin
          if (io.out_ready) begin
            if (j == last_out) begin
              j    <= '0;
              done <= 1'b1;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_n      = state;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.out_data  = '0;
    busy         = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) state_n = ACCEPT;
      end
      ACCEPT: begin
        io.in_ready = 1'b1;
        if (io.in_valid) state_n = SCATTER;
      end
      SCATTER: begin
        if (k == last_tap) state_n = last_pix ? DRAIN : ACCEPT;
      end
      DRAIN: begin
        io.out_valid = 1'b1;
        io.out_data  = acc[j];
        if (io.out_ready && j == last_out) state_n = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_conv_transpose_stream.sv
// tb_conv_transpose_stream: directed vectors for conv_transpose_stream at default parameters
// (2x2 input, 5x5 filter, stride 2 -> 7x7 output).
module tb_conv_transpose_stream;
  localparam int NT   = 25;
  localparam int NOUT = 49;
  localparam int NPIX = 4;
  localparam logic [31:0] ONE = 32'h0000_8000;
`ifdef CONV_TRANSPOSE_SATURATE_EN
  localparam logic [31:0] T5_OUT0 = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] T5_OUT0 = 32'hFFFF_0000;
`endif

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] exp;
  } spot_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [NT-1:0][31:0] filter;
  logic               busy;
  logic               done;

  conv_transpose_stream_if bus();

  conv_transpose_stream dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .filter (filter),
    .io     (bus.slave),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int                  n_cmp = 0;
  int                  n_bad = 0;
  logic [NT-1:0][31:0] filt;
  logic [31:0]         pix [NPIX];
  logic [31:0]         got [NOUT];
  int                  n_got;
  int                  n_done;
  spot_t               spots [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Number of 2x2 input positions whose 5x5 footprint (stride 2) covers output coordinate v.
  function automatic int cover_cnt(input int v);
    return ((v <= 4) ? 1 : 0) + ((v >= 2) ? 1 : 0);
  endfunction

  function automatic logic [31:0] exp_word(input int kind, input int idx);
    int y, x;
    y = idx / 7;
    x = idx % 7;
    case (kind)
      1:       return 32'(cover_cnt(y) * cover_cnt(x) * 32768);
      2:       return (y >= 2 && x >= 2) ? 32'(((y - 2) * 5 + (x - 2)) * 65536) : 32'h0;
      4:       return (idx == 0) ? 32'hFFFF_8000 : 32'h0;
      5:       return (idx == 0) ? T5_OUT0 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge one cycle after done.
  task automatic run_job(input int kind, input bit gapped, input bit stall, input bit mid_start);
    int          sent;
    bit          rdy;
    bit          prev_stall;
    logic [31:0] prev_data;
    sent       = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    n_got      = 0;
    n_done     = 0;
    for (int i = 0; i < NOUT; i++) got[i] = 'x;
    filter = filt;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    filter = {NT{32'h1234_5678}};
    for (int cyc = 0; cyc < 3000 && n_got < NOUT; cyc++) begin
      if (done) n_done++;
      start = (mid_start && cyc == 20);
      if (prev_stall) check("valid_held", bus.out_valid, 1'b1);
      if (bus.out_valid) begin
        if (prev_stall) check("data_held", bus.out_data, prev_data);
        rdy = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        bus.out_ready = rdy;
        if (rdy) begin
          got[n_got] = bus.out_data;
          n_got++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_data  = bus.out_data;
        end
      end else begin
        bus.out_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b0;
        prev_stall    = 1'b0;
      end
      if (sent < NPIX) begin
        bus.in_valid = gapped ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.in_data  = bus.in_valid ? pix[sent] : 32'hDEAD_BEEF;
        if (bus.in_valid && bus.in_ready) sent++;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
      end
      if (n_got < NOUT) @(negedge clk);
    end
    start = 1'b0;
    check($sformatf("t%0d words", kind), 32'(n_got), 32'(NOUT));
    check($sformatf("t%0d early_done", kind), 32'(n_done), 32'd0);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check($sformatf("t%0d done_pulse", kind), done, 1'b1);
    check($sformatf("t%0d valid_drop", kind), bus.out_valid, 1'b0);
    @(negedge clk);
    check($sformatf("t%0d done_single", kind), done, 1'b0);
    check($sformatf("t%0d busy_end", kind), busy, 1'b0);
    for (int i = 0; i < NOUT; i++)
      check($sformatf("t%0d map[%0d]", kind, i), got[i], exp_word(kind, i));
    foreach (spots[s])
      if (spots[s].kind == kind)
        check($sformatf("t%0d out[%0d]", kind, spots[s].idx), got[spots[s].idx], spots[s].exp);
  endtask

  task automatic set_unit_job();
    for (int i = 0; i < NT; i++) filt[i] = ONE;
    for (int i = 0; i < NPIX; i++) pix[i] = ONE;
  endtask

  initial begin
    int sent;
    spots[0] = '{1, 0,  32'h0000_8000};
    spots[1] = '{1, 3,  32'h0001_0000};
    spots[2] = '{1, 24, 32'h0002_0000};
    spots[3] = '{2, 48, 32'h0018_0000};
    spots[4] = '{2, 16, 32'h0000_0000};
    spots[5] = '{2, 0,  32'h0000_0000};
    spots[6] = '{4, 0,  32'hFFFF_8000};
    spots[7] = '{4, 1,  32'h0000_0000};
    spots[8] = '{5, 0,  T5_OUT0};

    rst           = 1'b1;
    start         = 1'b0;
    filter        = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset busy", busy, 1'b0);
    check("reset in_ready", bus.in_ready, 1'b0);
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset out_data", bus.out_data, 32'h0);
    check("reset done", done, 1'b0);

    // 1: unit filter, unit pixels
    set_unit_job();
    run_job(1, 1'b0, 1'b0, 1'b0);

    // 2: ramp filter, single 2.0 pixel at (1,1); starts the cycle after done
    for (int i = 0; i < NT; i++) filt[i] = 32'(i * 32768);
    pix = '{32'h0, 32'h0, 32'h0, 32'h0001_0000};
    run_job(2, 1'b0, 1'b0, 1'b0);

    // 3: test 1 under back-pressure and gapped input
    set_unit_job();
    run_job(1, 1'b1, 1'b1, 1'b0);

    // 4: negative pixel
    filt = '0;
    filt[0] = ONE;
    pix = '{32'hFFFF_8000, 32'h0, 32'h0, 32'h0};
    run_job(4, 1'b0, 1'b0, 1'b0);

    // 5: product out of 32-bit range
    filt = '0;
    filt[0] = 32'h0001_0000;
    pix = '{32'h7FFF_8000, 32'h0, 32'h0, 32'h0};
    run_job(5, 1'b0, 1'b0, 1'b0);

    // 6: reset during the scatter of pixel 2, then a clean rerun of test 1
    set_unit_job();
    filter = filt;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sent  = 0;
    for (int cyc = 0; cyc < 500 && sent < 3; cyc++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = pix[sent];
      if (bus.in_ready) sent++;
      @(negedge clk);
    end
    check("t6 pixels_before_rst", 32'(sent), 32'd3);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("t6 busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("t6 rst busy", busy, 1'b0);
    check("t6 rst in_ready", bus.in_ready, 1'b0);
    check("t6 rst out_valid", bus.out_valid, 1'b0);
    check("t6 rst done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("t6 idle done", done, 1'b0);
    run_job(1, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
